pipe_ctrl_param: RTL and testbench

Parametrised pipeline controller for the OpenMIPS core. It generalises the existing stall/flush unit to N stall-requesting stages and a configurable exception vector base, and adds three things:
- a multi-cycle flush sequencer;
- a valid/ack redirect handshake towards fetch;
- a stall watchdog.

It sits between the stage stall requests, MEM exception reporting and CP0 on one side, and the PC and pipeline registers on the other.

---
 rtl/pipe_ctrl_param.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_ctrl_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_param.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_param
// Pipeline controller for the OpenMIPS core: stall vector generation for
// STAGES stall-requesting stages, exception redirect with a multi-cycle flush
// sequencer, a valid/ack redirect handshake towards fetch, and a stall watchdog.
//
// Ports:
//   clk             clock
//   rst             synchronous active-low reset (all outputs forced low while 0)
//   stallreq_i      per-stage stall request, bit 0 = PC, bit STAGES-1 = WB
//   excepttype_i    exception code from MEM, 0 = none
//   cp0_epc_i       EPC from CP0 (eret target)
//   cp0_ebase_i     exception base from CP0
//   new_pc_o        redirect target
//   new_pc_valid_o  redirect target valid
//   new_pc_ack_i    fetch accepted the redirect
//   flush_o         flush all pipeline registers
//   stall_o         stall vector, 1 = hold the stage
//   stall_timeout_o one-cycle watchdog pulse
//   busy_o          exception sequence in progress
// -----------------------------------------------------------------------------
module pipe_ctrl_param #(
    parameter int                 STAGES        = 6,
    parameter int                 DATA_W        = 32,
    parameter int                 FLUSH_CYCLES  = 1,
    parameter int                 STALL_TIMEOUT = 255,
    parameter logic [DATA_W-1:0]  VEC_INT_OFF   = 32'h0000_0020,
    parameter logic [DATA_W-1:0]  VEC_EXC_OFF   = 32'h0000_0040
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [DATA_W-1:0] cp0_epc_i,
    input  logic [DATA_W-1:0] cp0_ebase_i,
    output logic [DATA_W-1:0] new_pc_o,
    output logic              new_pc_valid_o,
    input  logic              new_pc_ack_i,
    output logic              flush_o,
    output logic [STAGES-1:0] stall_o,
    output logic              stall_timeout_o,
    output logic              busy_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              ack_seen_q, ack_seen_d;
    logic              timeout_q;

    logic              exc_s;
    logic [DATA_W-1:0] target_s;
    logic [STAGES-1:0] stall_s;

    // Redirect target for a nonzero exception code; additions wrap naturally.
    function automatic logic [DATA_W-1:0] decode_target(
        input logic [31:0]       code,
        input logic [DATA_W-1:0] epc,
        input logic [DATA_W-1:0] ebase
    );
        case (code)
            32'h0000_000f: decode_target = ebase + VEC_INT_OFF;
            32'h0000_000e: decode_target = epc;
            default:       decode_target = ebase + VEC_EXC_OFF;
        endcase
    endfunction

    assign exc_s    = (excepttype_i != 32'h0000_0000);
    assign target_s = decode_target(excepttype_i, cp0_epc_i, cp0_ebase_i);

    // Thermometer stall vector: every stage at or below the highest requester holds.
    always_comb begin : p_stall_vec
        logic acc_v;
        acc_v   = 1'b0;
        stall_s = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc_v      = acc_v | stallreq_i[i];
            stall_s[i] = acc_v;
        end
    end

    // Next-state logic of the exception sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        ack_seen_d  = ack_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_s) begin
                    pc_d       = target_s;
                    ack_seen_d = new_pc_ack_i;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                    end else if (new_pc_ack_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Once ack_seen is set valid is low, so OR-ing the raw ack is harmless.
                ack_seen_d  = ack_seen_q | new_pc_ack_i;
                flush_cnt_d = flush_cnt_q - FC_W'(1);
                if (flush_cnt_q == FC_W'(1)) begin
                    state_d = (ack_seen_q || new_pc_ack_i) ? ST_IDLE : ST_WAIT_ACK;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_WAIT_ACK: begin
                if (new_pc_ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            flush_cnt_q <= '0;
            ack_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            ack_seen_q  <= ack_seen_d;
        end
    end

    // Output decode; reset forces every output low in the same cycle.
    always_comb begin
        new_pc_o        = '0;
        new_pc_valid_o  = 1'b0;
        flush_o         = 1'b0;
        stall_o         = '0;
        busy_o          = 1'b0;
        stall_timeout_o = 1'b0;
        if (!rst) begin
            stall_o = '0;
        end else begin
            stall_timeout_o = timeout_q;
            case (state_q)
                ST_IDLE: begin
                    if (exc_s) begin
                        flush_o        = 1'b1;
                        new_pc_valid_o = 1'b1;
                        new_pc_o       = target_s;
                    end else begin
                        stall_o = stall_s;
                    end
                end
                ST_FLUSH: begin
                    busy_o         = 1'b1;
                    flush_o        = 1'b1;
                    new_pc_valid_o = !ack_seen_q;
                    new_pc_o       = pc_q;
                end
                ST_WAIT_ACK: begin
                    busy_o         = 1'b1;
                    stall_o        = '1;
                    new_pc_valid_o = 1'b1;
                    new_pc_o       = pc_q;
                end
                default: begin
                    busy_o = 1'b0;
                end
            endcase
        end
    end

    if (STALL_TIMEOUT > 0) begin : g_wd
        localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
        logic [WD_W-1:0] wd_cnt_q;
        logic            wd_inc_s;

        assign wd_inc_s = (state_q == ST_IDLE) && !exc_s && (stall_s != '0);

        // Watchdog: count consecutive stalled IDLE cycles, pulse and restart at the limit.
        always_ff @(posedge clk) begin
            if (!rst) begin
                wd_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end else if (wd_inc_s) begin
                if (wd_cnt_q == WD_W'(STALL_TIMEOUT - 1)) begin
                    wd_cnt_q  <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    wd_cnt_q  <= wd_cnt_q + WD_W'(1);
                    timeout_q <= 1'b0;
                end
            end else begin
                wd_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end
        end
    end else begin : g_no_wd
        assign timeout_q = 1'b0;
    end

endmodule

// File: tb/tb_pipe_ctrl_param.sv
// Directed testbench for pipe_ctrl_param: a default instance (d_*) and an
// instance with FLUSH_CYCLES=3, STALL_TIMEOUT=4 (a_*) share the same inputs.
module tb_pipe_ctrl_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stallreq = 6'b0;
    logic [31:0] exc = 32'h0;
    logic [31:0] epc = 32'h0;
    logic [31:0] ebase = 32'h0;
    logic        ack = 1'b0;

    logic [31:0] d_pc, a_pc;
    logic        d_valid, a_valid, d_flush, a_flush, d_to, a_to, d_busy, a_busy;
    logic [5:0]  d_stall, a_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl_param u_dflt (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc),
        .cp0_epc_i(epc), .cp0_ebase_i(ebase), .new_pc_o(d_pc),
        .new_pc_valid_o(d_valid), .new_pc_ack_i(ack), .flush_o(d_flush),
        .stall_o(d_stall), .stall_timeout_o(d_to), .busy_o(d_busy)
    );

    pipe_ctrl_param #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) u_alt (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc),
        .cp0_epc_i(epc), .cp0_ebase_i(ebase), .new_pc_o(a_pc),
        .new_pc_valid_o(a_valid), .new_pc_ack_i(ack), .flush_o(a_flush),
        .stall_o(a_stall), .stall_timeout_o(a_to), .busy_o(a_busy)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; stallreq = 6'b0; exc = 32'h0; ack = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        stallreq = 6'b111111; exc = 32'h8; ack = 1'b1; ebase = 32'h1000;
        #2;
        n_cmp++;
        if ({d_pc, d_valid, d_flush, d_stall, d_to, d_busy} !== 42'b0) begin
            n_err++; $display("FAIL reset_dflt act=%h exp=0", {d_pc, d_valid, d_flush, d_stall, d_to, d_busy});
        end
        n_cmp++;
        if ({a_pc, a_valid, a_flush, a_stall, a_to, a_busy} !== 42'b0) begin
            n_err++; $display("FAIL reset_alt act=%h exp=0", {a_pc, a_valid, a_flush, a_stall, a_to, a_busy});
        end
        next_cycle();
        rst = 1'b1; stallreq = 6'b0; exc = 32'h0; ack = 1'b0;
        #2;
        n_cmp++;
        if ({d_pc, d_valid, d_flush, d_stall, d_to, d_busy} !== 42'b0) begin
            n_err++; $display("FAIL post_reset act=%h exp=0", {d_pc, d_valid, d_flush, d_stall, d_to, d_busy});
        end
        next_cycle();
    endtask

    task automatic test_stall_vec();
        logic [5:0] req_v [6];
        logic [5:0] exp_v [6];
        req_v = '{6'b001000, 6'b001100, 6'b000100, 6'b100000, 6'b000001, 6'b000000};
        exp_v = '{6'b001111, 6'b001111, 6'b000111, 6'b111111, 6'b000001, 6'b000000};
        for (int i = 0; i < 6; i++) begin
            stallreq = req_v[i];
            #2;
            n_cmp++;
            if ({d_flush, d_valid, d_busy, d_stall} !== {3'b000, exp_v[i]}) begin
                n_err++; $display("FAIL stall_vec[%0d] act=%b exp=%b", i, {d_flush, d_valid, d_busy, d_stall}, {3'b000, exp_v[i]});
            end
            next_cycle();
        end
        stallreq = 6'b0;
    endtask

    task automatic test_exc_ack_same_cycle();
        do_reset();
        ebase = 32'hBFC0_0000; exc = 32'h08; stallreq = 6'b001000; ack = 1'b1;
        #2;
        n_cmp++;
        if ({d_flush, d_valid, d_busy, d_stall, d_pc} !== {3'b110, 6'b0, 32'hBFC0_0040}) begin
            n_err++; $display("FAIL exc_c0 act=%h exp=%h", {d_flush, d_valid, d_busy, d_stall, d_pc}, {3'b110, 6'b0, 32'hBFC0_0040});
        end
        next_cycle();
        exc = 32'h0; stallreq = 6'b0; ack = 1'b0;
        #2;
        n_cmp++;
        if ({d_flush, d_valid, d_busy, d_stall, d_pc} !== 41'b0) begin
            n_err++; $display("FAIL exc_c1 act=%h exp=0", {d_flush, d_valid, d_busy, d_stall, d_pc});
        end
        next_cycle();
    endtask

    task automatic test_decode();
        logic [31:0] code_v [4];
        logic [31:0] exp_v  [4];
        do_reset();
        ebase = 32'hFFFF_FFF0; epc = 32'h1234_5678; ack = 1'b1;
        code_v = '{32'h0f, 32'h3f, 32'h01, 32'h0e};
        exp_v  = '{32'h0000_0010, 32'h0000_0030, 32'h0000_0030, 32'h1234_5678};
        for (int i = 0; i < 4; i++) begin
            exc = code_v[i];
            #2;
            n_cmp++;
            if (d_pc !== exp_v[i]) begin
                n_err++; $display("FAIL decode[%0d] act=%h exp=%h", i, d_pc, exp_v[i]);
            end
            next_cycle();
        end
        exc = 32'h0; ack = 1'b0;
    endtask

    task automatic test_wait_ack();
        do_reset();
        exc = 32'h0e; epc = 32'h8000_1234; ack = 1'b0;
        #2;
        n_cmp++;
        if ({d_flush, d_valid, d_busy, d_pc} !== {3'b110, 32'h8000_1234}) begin
            n_err++; $display("FAIL wack_c0 act=%h exp=%h", {d_flush, d_valid, d_busy, d_pc}, {3'b110, 32'h8000_1234});
        end
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            exc = (c == 2) ? 32'h0f : 32'h0;
            epc = 32'h0;
            ack = (c == 3);
            #2;
            n_cmp++;
            if ({d_flush, d_valid, d_busy, d_stall, d_pc} !== {3'b011, 6'b111111, 32'h8000_1234}) begin
                n_err++; $display("FAIL wack_c%0d act=%h exp=%h", c, {d_flush, d_valid, d_busy, d_stall, d_pc}, {3'b011, 6'b111111, 32'h8000_1234});
            end
            next_cycle();
        end
        exc = 32'h0; ack = 1'b0;
        #2;
        n_cmp++;
        if ({d_flush, d_valid, d_busy, d_stall} !== 9'b0) begin
            n_err++; $display("FAIL wack_c4 act=%b exp=0", {d_flush, d_valid, d_busy, d_stall});
        end
        next_cycle();
    endtask

    task automatic test_multi_flush();
        logic [3:0] exp_v [4];
        do_reset();
        ebase = 32'h0;
        // {flush, valid, busy, stall_any} per cycle for the FLUSH_CYCLES=3 instance
        exp_v = '{4'b1100, 4'b1110, 4'b1010, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            exc = (c == 0) ? 32'h0f : 32'h0;
            ack = (c == 1);
            #2;
            n_cmp++;
            if ({a_flush, a_valid, a_busy, |a_stall} !== exp_v[c]) begin
                n_err++; $display("FAIL mflush_c%0d act=%b exp=%b", c, {a_flush, a_valid, a_busy, |a_stall}, exp_v[c]);
            end
            if (c < 2) begin
                n_cmp++;
                if (a_pc !== 32'h20) begin
                    n_err++; $display("FAIL mflush_pc_c%0d act=%h exp=00000020", c, a_pc);
                end
            end
            next_cycle();
        end
        exc = 32'h0; ack = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        stallreq = 6'b000100;
        for (int c = 0; c < 10; c++) begin
            #2;
            n_cmp++;
            if ({a_to, d_to} !== {((c == 4) || (c == 8)), 1'b0}) begin
                n_err++; $display("FAIL wd_c%0d act=%b exp=%b", c, {a_to, d_to}, {((c == 4) || (c == 8)), 1'b0});
            end
            next_cycle();
        end
        do_reset();
        for (int c = 0; c < 8; c++) begin
            stallreq = (c < 2) ? 6'b000100 : 6'b0;
            #2;
            n_cmp++;
            if (a_to !== 1'b0) begin
                n_err++; $display("FAIL wd_drop_c%0d act=%b exp=0", c, a_to);
            end
            next_cycle();
        end
        stallreq = 6'b0;
    endtask

    task automatic test_reset_mid_seq();
        do_reset();
        exc = 32'h08; ebase = 32'h100; ack = 1'b0;
        next_cycle();
        exc = 32'h0;
        #2;
        n_cmp++;
        if ({d_valid, d_busy, d_stall} !== 8'b11111111) begin
            n_err++; $display("FAIL mid_pre act=%b exp=11111111", {d_valid, d_busy, d_stall});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({d_pc, d_valid, d_flush, d_stall, d_to, d_busy} !== 42'b0) begin
            n_err++; $display("FAIL mid_rst act=%h exp=0", {d_pc, d_valid, d_flush, d_stall, d_to, d_busy});
        end
        next_cycle();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({d_pc, d_valid, d_flush, d_stall, d_busy} !== 41'b0) begin
            n_err++; $display("FAIL mid_post act=%h exp=0", {d_pc, d_valid, d_flush, d_stall, d_busy});
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_stall_vec();
        test_exc_ack_same_cycle();
        test_decode();
        test_wait_ack();
        test_multi_flush();
        test_watchdog();
        test_reset_mid_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
